pu_or1k_pfpu32_sched: RTL and testbench

//  Sequencer for the pfpu32 cluster. Accepts one FP op at a time from execute.

---
 rtl/pu_or1k_pfpu32_sched.sv | 141 ++++++++++++++
 tb/tb_pu_or1k_pfpu32_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_or1k_pfpu32_sched.sv
// pu_or1k_pfpu32_sched: one-op-at-a-time sequencer for the pfpu32 cluster (issue, rounding steer, watchdog).
// Define PU_OR1K_PFPU32_DIV_EN to issue op 2 to the divider; otherwise op 2 completes at once with err_o.
module pu_or1k_pfpu32_sched #(
    parameter int unsigned TIMEOUT = 63,
    parameter int unsigned CNT_W   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_i,
    input  logic       stall_i,
    input  logic       req_valid_i,
    input  logic [2:0] req_op_i,
    output logic       req_ready_o,
    input  logic [5:0] unit_rdy_i,
    input  logic       rnd_rdy_i,
    output logic       adv_o,
    output logic [5:0] start_o,
    output logic [4:0] rnd_sel_o,
    output logic       done_o,
    output logic       err_o,
    input  logic       ack_i
);

`ifdef PU_OR1K_PFPU32_DIV_EN
    localparam logic [7:0] LEGAL_OPS = 8'b0011_1111;
`else
    localparam logic [7:0] LEGAL_OPS = 8'b0011_1011;
`endif
    localparam logic [2:0]       OP_CMP = 3'd5;
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_UNIT,
        S_WAIT_RND,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       rnd_sel_q, rnd_sel_d;
    logic             err_q, err_d;

    logic             adv;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;
    logic [7:0]       op_oh;
    logic [7:0]       unit_rdy_x;

    assign op_oh      = 8'b0000_0001 << op_q;
    assign unit_rdy_x = {2'b00, unit_rdy_i};
    assign adv        = (state_q == S_ISSUE || state_q == S_WAIT_UNIT || state_q == S_WAIT_RND) && !stall_i;
    assign cnt_inc    = (cnt_q == TO_CNT) ? cnt_q : cnt_q + 1'b1;
    // The watchdog wins over a completion arriving on the same advancing cycle.
    assign timeout_hit = adv && (cnt_inc == TO_CNT);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        rnd_sel_d = rnd_sel_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_d      = req_op_i;
                    err_d     = !LEGAL_OPS[req_op_i];
                    rnd_sel_d = '0;
                    state_d   = LEGAL_OPS[req_op_i] ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (adv) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_UNIT;
                end
            end
            S_WAIT_UNIT: begin
                if (adv) cnt_d = cnt_inc;
                if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (unit_rdy_x[op_q]) begin
                    if (op_q == OP_CMP) begin
                        state_d = S_DONE;
                    end else begin
                        rnd_sel_d = op_oh[4:0];
                        state_d   = S_WAIT_RND;
                    end
                end
            end
            S_WAIT_RND: begin
                if (adv) cnt_d = cnt_inc;
                if (timeout_hit || rnd_rdy_i) begin
                    err_d     = timeout_hit;
                    rnd_sel_d = '0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                rnd_sel_d = '0;
                if (ack_i) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d   = S_IDLE;
            rnd_sel_d = '0;
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            rnd_sel_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            rnd_sel_q <= rnd_sel_d;
            err_q     <= err_d;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign adv_o       = adv;
    assign start_o     = (state_q == S_ISSUE && adv && !flush_i) ? (op_oh[5:0] & LEGAL_OPS[5:0]) : '0;
    assign rnd_sel_o   = flush_i ? '0 : (rnd_sel_q & LEGAL_OPS[4:0]);
    assign done_o      = (state_q == S_DONE) && !flush_i;
    assign err_o       = done_o && err_q;

endmodule

// File: tb/tb_pu_or1k_pfpu32_sched.sv
// Scoreboard bench for pu_or1k_pfpu32_sched: directed scenarios plus randomized ops against a reference model.
module tb_pu_or1k_pfpu32_sched;
    localparam int TO = 8;
`ifdef PU_OR1K_PFPU32_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b0, flush_i = 1'b0, stall_i = 1'b0, req_valid_i = 1'b0;
    logic [2:0] req_op_i = '0;
    logic [5:0] unit_rdy_i = '0;
    logic       rnd_rdy_i = 1'b0, ack_i = 1'b0;
    logic       req_ready_o, adv_o, done_o, err_o;
    logic [5:0] start_o;
    logic [4:0] rnd_sel_o;

    pu_or1k_pfpu32_sched #(.TIMEOUT(TO), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
        .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_ready_o(req_ready_o),
        .unit_rdy_i(unit_rdy_i), .rnd_rdy_i(rnd_rdy_i), .adv_o(adv_o),
        .start_o(start_o), .rnd_sel_o(rnd_sel_o), .done_o(done_o), .err_o(err_o),
        .ack_i(ack_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic [5:0] start;
        logic [1:0] scnt;
        logic [4:0] rnd;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outcome of one op: wait cycle c completes it, cycle t is where the TO-th advance lands.
    function automatic void model(input int op, input logic [39:0] st, input int d, input int r,
                                  output exp_t e, output int lat, output bit legal);
        int c, cnt, t;
        legal = (op <= 5) && (op != 2 || DIV_EN);
        e = '0;
        lat = 0;
        if (!legal) begin
            e.err = 1'b1;
            return;
        end
        c = (op == 5) ? d : d + 1 + r;
        cnt = 0;
        t = 1000;
        for (int i = 0; i < 40; i++) begin
            if (!st[i]) cnt++;
            if (cnt == TO && t == 1000) t = i;
        end
        e.err   = (t <= c);
        e.start = 6'(1 << op);
        e.scnt  = 2'd1;
        e.rnd   = (op < 5 && t > d) ? 5'(1 << op) : 5'd0;
        lat     = (t < c) ? t : c;
    endfunction

    task automatic ack_phase();
        int k;
        k = int'($urandom_range(0, 2));
        for (int j = 0; j < k; j++) begin
            stall_i = 1'($urandom_range(0, 1));
            tick();
        end
        chk("done_hold", done_o, 1);
        stall_i = 1'b0;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("ack_idle", req_ready_o, 1);
        chk("ack_done_clr", done_o, 0);
    endtask

    task automatic txn(input int op, input int ns, input int d, input int r,
                       input logic [39:0] st, input logic [5:0] noise);
        exp_t e;
        int lat, i;
        bit legal;
        logic [5:0] ob;
        model(op, st, d, r, e, lat, legal);
        q.push_back(e);
        ob = 6'(1 << op);
        req_valid_i = 1'b1;
        req_op_i = 3'(op);
        tick();
        req_valid_i = 1'b0;
        if (!legal) begin
            chk("illegal_done", done_o, 1);
        end else begin
            for (int k = 0; k < ns; k++) begin
                stall_i = 1'b1;
                tick();
            end
            stall_i = 1'b0;
            tick();
            for (i = 0; i < 40; i++) begin
                stall_i    = st[i];
                unit_rdy_i = (noise & ~ob) | ((i == d) ? ob : 6'd0);
                rnd_rdy_i  = (op != 5 && i == d + 1 + r) || (i < d && $urandom_range(0, 1) == 1);
                tick();
                if (done_o) break;
            end
            stall_i = 1'b0;
            unit_rdy_i = '0;
            rnd_rdy_i = 1'b0;
            chk("done_latency", 32'(i), 32'(lat));
        end
        ack_phase();
    endtask

    // Monitor: collects start/rnd_sel activity per op and checks it when done_o rises.
    logic [5:0] st_or = '0;
    logic [4:0] rs_or = '0;
    int         st_cnt = 0;
    logic       done_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (start_o != 6'd0) begin
                st_or = st_or | start_o;
                st_cnt++;
            end
            rs_or = rs_or | rnd_sel_o;
            if (done_o && !done_prev) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_done actual=1 required=0");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_err", err_o, e.err);
                    chk("sb_start", st_or, e.start);
                    chk("sb_start_cnt", 32'(st_cnt), 32'(e.scnt));
                    chk("sb_rnd_sel", rs_or, e.rnd);
                end
            end
            if (req_ready_o) begin
                st_or = '0;
                rs_or = '0;
                st_cnt = 0;
            end
            done_prev = done_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [39:0] st;
        #1 rst = 1'b1;
        #2;
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_adv", adv_o, 0);
        chk("rst_start", start_o, 0);
        chk("rst_rnd_sel", rnd_sel_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // add, no stall, unit ready after 3 wait cycles
        q.push_back('{err: 1'b0, start: 6'b000001, scnt: 2'd1, rnd: 5'b00001});
        req_valid_i = 1'b1;
        req_op_i = 3'd0;
        tick();
        req_valid_i = 1'b0;
        chk("t1_start", start_o, 6'b000001);
        tick();
        chk("t1_start_clr", start_o, 0);
        tick();
        tick();
        tick();
        unit_rdy_i = 6'b000001;
        tick();
        unit_rdy_i = '0;
        chk("t1_rnd_sel", rnd_sel_o, 5'b00001);
        rnd_rdy_i = 1'b1;
        tick();
        rnd_rdy_i = 1'b0;
        chk("t1_done", done_o, 1);
        chk("t1_rnd_sel_done", rnd_sel_o, 0);
        ack_phase();

        // mul stalled in ISSUE for 4 cycles
        q.push_back('{err: 1'b0, start: 6'b000010, scnt: 2'd1, rnd: 5'b00010});
        req_valid_i = 1'b1;
        req_op_i = 3'd1;
        tick();
        req_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            stall_i = 1'b1;
            #1;
            chk("t3_stall_start", start_o, 0);
            chk("t3_stall_adv", adv_o, 0);
            tick();
        end
        stall_i = 1'b0;
        #1;
        chk("t3_start", start_o, 6'b000010);
        chk("t3_adv", adv_o, 1);
        tick();
        unit_rdy_i = 6'b000010;
        tick();
        unit_rdy_i = '0;
        rnd_rdy_i = 1'b1;
        tick();
        rnd_rdy_i = 1'b0;
        chk("t3_done", done_o, 1);
        ack_phase();

        txn(5, 0, 2, 0, '0, 6'b011111);     // cmp
        txn(7, 0, 0, 0, '0, 6'b000000);     // illegal
        txn(6, 0, 0, 0, '0, 6'b000000);     // illegal
        txn(1, 0, 30, 0, '0, 6'b000000);    // watchdog, no stall
        txn(1, 2, 30, 0, 40'h5, 6'b000000); // watchdog with stalls in WAIT
        txn(2, 0, 1, 1, '0, 6'b000000);     // divider op

        // flush in WAIT_RND together with rnd_rdy
        req_valid_i = 1'b1;
        req_op_i = 3'd0;
        tick();
        req_valid_i = 1'b0;
        tick();
        unit_rdy_i = 6'b000001;
        tick();
        unit_rdy_i = '0;
        chk("t6_rnd_sel", rnd_sel_o, 5'b00001);
        rnd_rdy_i = 1'b1;
        flush_i = 1'b1;
        #1;
        chk("t6_flush_rnd_sel", rnd_sel_o, 0);
        chk("t6_flush_done", done_o, 0);
        tick();
        flush_i = 1'b0;
        rnd_rdy_i = 1'b0;
        chk("t6_idle", req_ready_o, 1);
        chk("t6_no_done", done_o, 0);
        tick();
        tick();
        chk("t6_no_done_late", done_o, 0);

        for (int n = 0; n < 80; n++) begin
            for (int b = 0; b < 40; b++) st[b] = ($urandom_range(0, 3) == 0);
            txn(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)), st, 6'($urandom));
        end

        tick();
        tick();
        chk("sb_empty", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
